udp_head_rx: RTL and testbench

Receive-side UDP header parser for the 16-bit IP payload stream. Consumes the 8-byte UDP header from the stream handed over by the IPv4 receive layer, filters on destination port, checks the length field against the actual payload, optionally verifies the checksum, and forwards the payload with one registered cycle of latency to the application layer. It is the mirror of the UDP header transmit block.

---
 rtl/udp_head_rx_pkg.sv | 27 ++
 rtl/udp_rx_cs.sv | 45 ++++
 rtl/udp_head_rx.sv | 218 +++++++++++++++++++++
 tb/tb_udp_head_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/udp_head_rx_pkg.sv
// Shared definitions for the UDP receive header parser and its checksum helper.
package udp_head_rx_pkg;

  // UDP header size in bytes
  localparam int unsigned UDP_HEAD_N = 8;

  // Bit offsets of the header fields within {cs, len, dst, src}
  localparam int unsigned UDP_SRC_OFF = 0;
  localparam int unsigned UDP_DST_OFF = 16;
  localparam int unsigned UDP_LEN_OFF = 32;
  localparam int unsigned UDP_CS_OFF  = 48;

  typedef enum logic [1:0] {
    StIdle,
    StHead,
    StPayload,
    StDrop
  } udp_rx_state_t;

  // 16-bit one's-complement add with end-around carry folded back in
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/udp_rx_cs.sv
// One's-complement checksum accumulator for the UDP receive path.
// sum presents the running sum including the beat currently on the inputs.
module udp_rx_cs
  import udp_head_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CS_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [KEEP_W-1:0] keep,
  input  logic [CS_W-1:0]   pseudo_cs,
  output logic [CS_W-1:0]   sum
);

  logic [CS_W-1:0] acc;
  logic [CS_W-1:0] lane;
  logic [CS_W-1:0] base;

  // Zero-pad a partial final beat in the low byte lane; a new segment restarts from pseudo_cs
  always_comb begin
    lane = '0;
    if (&keep) begin
      lane = data;
    end else if (keep != '0) begin
      lane = {data[DATA_W-1:DATA_W-8], 8'h00};
    end
    base = start ? pseudo_cs : acc;
    sum  = ones_add(base, lane);
  end

  // Running accumulator, advanced on every valid beat
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (valid) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/udp_head_rx.sv
// UDP receive header parser: strips the 8-byte header, filters on destination port,
// checks the length field against the received byte count and forwards the payload
// one cycle later. Defining UDP_RX_CS_EN adds checksum verification.
module udp_head_rx
  import udp_head_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned PORT_W = 16,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned CS_W   = 16,
  parameter logic [PORT_W-1:0] DST_PORT = 16'd18170
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [CS_W-1:0]   pseudo_cs_i,
  output logic              head_v_o,
  output logic [PORT_W-1:0] src_port_o,
  output logic [PORT_W-1:0] dst_port_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              err_o
);

  localparam logic [1:0] SRC_BEAT = 2'(UDP_SRC_OFF / DATA_W);
  localparam logic [1:0] DST_BEAT = 2'(UDP_DST_OFF / DATA_W);
  localparam logic [1:0] LEN_BEAT = 2'(UDP_LEN_OFF / DATA_W);
  localparam logic [1:0] CS_BEAT  = 2'(UDP_CS_OFF / DATA_W);
  localparam logic [LEN_W-1:0] HEAD_LEN = LEN_W'(UDP_HEAD_N);

  udp_rx_state_t     state;
  logic [1:0]        beat_cnt;
  logic [PORT_W-1:0] src_cap;
  logic [PORT_W-1:0] dst_cap;
  logic [LEN_W-1:0]  len_cap;
  logic [CS_W-1:0]   cs_cap;
  logic              dst_bad;
  logic              len_bad;
  logic              first_pay;
  logic [LEN_W:0]    byte_cnt;
  logic [LEN_W:0]    keep_bytes;
  logic [LEN_W:0]    cnt_next;
  logic              cs_err_pay;
  logic              cs_err_head;

  // Byte count including the current beat
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      keep_bytes = keep_bytes + (LEN_W + 1)'(keep_i[i]);
    end
    cnt_next = byte_cnt + keep_bytes;
  end

`ifdef UDP_RX_CS_EN
  logic [CS_W-1:0] cs_sum;

  udp_rx_cs #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
    .CS_W  (CS_W)
  ) u_cs (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid_i),
    .start    (start_i),
    .data     (data_i),
    .keep     (keep_i),
    .pseudo_cs(pseudo_cs_i),
    .sum      (cs_sum)
  );

  // A zero checksum field disables the check; the beat-3 variant sees the field on data_i
  assign cs_err_pay  = (cs_cap != '0) && (cs_sum != '1);
  assign cs_err_head = (data_i != '0) && (cs_sum != '1);
`else
  logic unused_cs;
  assign unused_cs   = ^{pseudo_cs_i, cs_cap};
  assign cs_err_pay  = 1'b0;
  assign cs_err_head = 1'b0;
`endif

  // Parser FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      beat_cnt   <= '0;
      src_cap    <= '0;
      dst_cap    <= '0;
      len_cap    <= '0;
      cs_cap     <= '0;
      dst_bad    <= 1'b0;
      len_bad    <= 1'b0;
      first_pay  <= 1'b0;
      byte_cnt   <= '0;
      head_v_o   <= 1'b0;
      src_port_o <= '0;
      dst_port_o <= '0;
      len_o      <= '0;
      valid_o    <= 1'b0;
      start_o    <= 1'b0;
      last_o     <= 1'b0;
      data_o     <= '0;
      keep_o     <= '0;
      err_o      <= 1'b0;
    end else begin
      valid_o  <= 1'b0;
      head_v_o <= 1'b0;
      err_o    <= 1'b0;
      if (valid_i) begin
        if (start_i) begin
          // A start outside IDLE aborts the open segment; PAYLOAD closes with an empty last beat
          if (state != StIdle) begin
            err_o <= 1'b1;
          end
          if (state == StPayload) begin
            valid_o <= 1'b1;
            start_o <= first_pay;
            last_o  <= 1'b1;
            data_o  <= '0;
            keep_o  <= '0;
          end
          src_cap <= data_i;
          dst_bad <= 1'b0;
          len_bad <= 1'b0;
          if (last_i) begin
            err_o <= 1'b1;
            state <= StIdle;
          end else begin
            beat_cnt <= SRC_BEAT + 2'd1;
            state    <= StHead;
          end
        end else begin
          unique case (state)
            StIdle: begin
            end
            StHead: begin
              beat_cnt <= beat_cnt + 2'd1;
              if (last_i && (beat_cnt != CS_BEAT)) begin
                err_o <= 1'b1;
                state <= StIdle;
              end else if (beat_cnt == DST_BEAT) begin
                dst_cap <= data_i;
                dst_bad <= (data_i != DST_PORT);
              end else if (beat_cnt == LEN_BEAT) begin
                len_cap <= data_i;
                len_bad <= (data_i < HEAD_LEN);
              end else if (beat_cnt == CS_BEAT) begin
                cs_cap <= data_i;
                if (dst_bad || len_bad) begin
                  if (last_i) begin
                    err_o <= 1'b1;
                    state <= StIdle;
                  end else begin
                    state <= StDrop;
                  end
                end else begin
                  head_v_o   <= 1'b1;
                  src_port_o <= src_cap;
                  dst_port_o <= dst_cap;
                  len_o      <= len_cap - HEAD_LEN;
                  byte_cnt   <= '0;
                  first_pay  <= 1'b1;
                  if (len_cap == HEAD_LEN) begin
                    // Zero-payload segment must close on this beat
                    if (last_i) begin
                      err_o <= cs_err_head;
                      state <= StIdle;
                    end else begin
                      state <= StDrop;
                    end
                  end else if (last_i) begin
                    err_o <= 1'b1;
                    state <= StIdle;
                  end else begin
                    state <= StPayload;
                  end
                end
              end else begin
                state <= StIdle;
              end
            end
            StPayload: begin
              valid_o   <= 1'b1;
              start_o   <= first_pay;
              first_pay <= 1'b0;
              last_o    <= last_i;
              data_o    <= data_i;
              keep_o    <= keep_i;
              byte_cnt  <= cnt_next;
              if (last_i) begin
                err_o <= (cnt_next != {1'b0, len_o}) || cs_err_pay;
                state <= StIdle;
              end
            end
            StDrop: begin
              if (last_i) begin
                err_o <= 1'b1;
                state <= StIdle;
              end
            end
            default: state <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_head_rx.sv
// Directed bench for udp_head_rx: header parse, port/length filtering, abort, runt, reset.
module tb_udp_head_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        start_i;
  logic        last_i;
  logic [15:0] data_i;
  logic [1:0]  keep_i;
  logic [15:0] pseudo_cs_i;
  logic        head_v_o;
  logic [15:0] src_port_o;
  logic [15:0] dst_port_o;
  logic [15:0] len_o;
  logic        valid_o;
  logic        start_o;
  logic        last_o;
  logic [15:0] data_o;
  logic [1:0]  keep_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udp_head_rx dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .start_i    (start_i),
    .last_i     (last_i),
    .data_i     (data_i),
    .keep_i     (keep_i),
    .pseudo_cs_i(pseudo_cs_i),
    .head_v_o   (head_v_o),
    .src_port_o (src_port_o),
    .dst_port_o (dst_port_o),
    .len_o      (len_o),
    .valid_o    (valid_o),
    .start_o    (start_o),
    .last_o     (last_o),
    .data_o     (data_o),
    .keep_o     (keep_o),
    .err_o      (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, then wait until its registered result is visible
  task automatic beat(input logic v, input logic s, input logic l, input logic [15:0] d,
                      input logic [1:0] k);
    valid_i = v;
    start_i = s;
    last_i  = l;
    data_i  = d;
    keep_i  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                     input logic [15:0] cs, input logic l);
    beat(1'b1, 1'b1, 1'b0, src, 2'b11);
    beat(1'b1, 1'b0, 1'b0, dst, 2'b11);
    beat(1'b1, 1'b0, 1'b0, len, 2'b11);
    beat(1'b1, 1'b0, l, cs, 2'b11);
  endtask

  initial begin
    reset       = 1'b1;
    valid_i     = 1'b0;
    start_i     = 1'b0;
    last_i      = 1'b0;
    data_i      = '0;
    keep_i      = '0;
    pseudo_cs_i = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_head_v", head_v_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_src", src_port_o, 0);
    chk("rst_len", len_o, 0);
    chk("rst_data", data_o, 0);
    reset = 1'b0;

    // Good segment, two payload beats
    hdr(16'h1234, 16'd18170, 16'd12, 16'h0000, 1'b0);
    chk("good_head_v", head_v_o, 1);
    chk("good_len", len_o, 4);
    chk("good_src", src_port_o, 16'h1234);
    chk("good_dst", dst_port_o, 16'd18170);
    chk("good_hdr_valid", valid_o, 0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    chk("good_p0_valid", valid_o, 1);
    chk("good_p0_start", start_o, 1);
    chk("good_p0_data", data_o, 16'hAABB);
    chk("good_p0_head_v", head_v_o, 0);
    beat(1'b1, 1'b0, 1'b1, 16'hCCDD, 2'b11);
    chk("good_p1_valid", valid_o, 1);
    chk("good_p1_start", start_o, 0);
    chk("good_p1_last", last_o, 1);
    chk("good_p1_data", data_o, 16'hCCDD);
    chk("good_p1_err", err_o, 0);
    beat(1'b0, 1'b0, 1'b0, 16'h0000, 2'b00);
    chk("good_idle_valid", valid_o, 0);

    // Wrong destination port: dropped
    hdr(16'h1234, 16'h0050, 16'd12, 16'h0000, 1'b0);
    chk("dport_head_v", head_v_o, 0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    chk("dport_p0_valid", valid_o, 0);
    beat(1'b1, 1'b0, 1'b1, 16'hCCDD, 2'b11);
    chk("dport_err", err_o, 1);
    chk("dport_valid", valid_o, 0);
    chk("dport_last_head_v", head_v_o, 0);

    // Length field 13, only 4 payload bytes
    hdr(16'h1234, 16'd18170, 16'd13, 16'h0000, 1'b0);
    chk("len13_len", len_o, 5);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    beat(1'b1, 1'b0, 1'b1, 16'hCCDD, 2'b11);
    chk("len13_last", last_o, 1);
    chk("len13_err", err_o, 1);

    // Length field 11 with partial last beat: 3 bytes match
    hdr(16'h1234, 16'd18170, 16'd11, 16'h0000, 1'b0);
    chk("len11_len", len_o, 3);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    beat(1'b1, 1'b0, 1'b1, 16'hCC00, 2'b01);
    chk("len11_keep", keep_o, 2'b01);
    chk("len11_last", last_o, 1);
    chk("len11_err", err_o, 0);

    // Length field 6: below header size, dropped
    hdr(16'h1234, 16'd18170, 16'd6, 16'h0000, 1'b0);
    chk("len6_head_v", head_v_o, 0);
    beat(1'b1, 1'b0, 1'b1, 16'hAABB, 2'b11);
    chk("len6_valid", valid_o, 0);
    chk("len6_err", err_o, 1);

    // Abort on second payload beat, new header starts in the same cycle
    hdr(16'h1234, 16'd18170, 16'd12, 16'h0000, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    chk("abort_p0_start", start_o, 1);
    beat(1'b1, 1'b1, 1'b0, 16'h4321, 2'b11);
    chk("abort_valid", valid_o, 1);
    chk("abort_last", last_o, 1);
    chk("abort_keep", keep_o, 2'b00);
    chk("abort_start", start_o, 0);
    chk("abort_err", err_o, 1);
    beat(1'b1, 1'b0, 1'b0, 16'd18170, 2'b11);
    beat(1'b1, 1'b0, 1'b0, 16'd10, 2'b11);
    beat(1'b1, 1'b0, 1'b0, 16'h0000, 2'b11);
    chk("abort_new_head_v", head_v_o, 1);
    chk("abort_new_src", src_port_o, 16'h4321);
    chk("abort_new_len", len_o, 2);
    beat(1'b1, 1'b0, 1'b1, 16'h5555, 2'b11);
    chk("abort_new_start", start_o, 1);
    chk("abort_new_last", last_o, 1);
    chk("abort_new_data", data_o, 16'h5555);
    chk("abort_new_err", err_o, 0);

    // Runt: last on header beat 2
    beat(1'b1, 1'b1, 1'b0, 16'h1234, 2'b11);
    beat(1'b1, 1'b0, 1'b0, 16'd18170, 2'b11);
    beat(1'b1, 1'b0, 1'b1, 16'd12, 2'b11);
    chk("runt_err", err_o, 1);
    chk("runt_head_v", head_v_o, 0);
    chk("runt_valid", valid_o, 0);
    beat(1'b1, 1'b0, 1'b0, 16'hBEEF, 2'b11);
    chk("idle_nostart_valid", valid_o, 0);
    chk("idle_nostart_err", err_o, 0);

    // Zero-payload segment closing on header beat 3
    hdr(16'h0001, 16'd18170, 16'd8, 16'h0000, 1'b1);
    chk("zero_head_v", head_v_o, 1);
    chk("zero_len", len_o, 0);
    chk("zero_err", err_o, 0);
    chk("zero_valid", valid_o, 0);

    // Reset in the middle of a payload
    hdr(16'h1234, 16'd18170, 16'd12, 16'h0000, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    chk("mid_p0_valid", valid_o, 1);
    reset = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 16'hCCDD, 2'b11);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_start", start_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_keep", keep_o, 0);
    chk("mid_rst_src", src_port_o, 0);
    chk("mid_rst_dst", dst_port_o, 0);
    chk("mid_rst_len", len_o, 0);
    chk("mid_rst_err", err_o, 0);
    reset = 1'b0;
    hdr(16'h0101, 16'd18170, 16'd10, 16'h0000, 1'b0);
    chk("post_rst_head_v", head_v_o, 1);
    chk("post_rst_src", src_port_o, 16'h0101);
    chk("post_rst_len", len_o, 2);
    beat(1'b1, 1'b0, 1'b1, 16'h7777, 2'b11);
    chk("post_rst_start", start_o, 1);
    chk("post_rst_last", last_o, 1);
    chk("post_rst_data", data_o, 16'h7777);
    chk("post_rst_err", err_o, 0);

`ifdef UDP_RX_CS_EN
    // 0x1111 + 0x1234 + 0x46FA + 0x000C + 0xAABB + 0xCCDD folds to 0xE1E4; field 0x1E1B completes it
    hdr(16'h1234, 16'd18170, 16'd12, 16'h1E1B, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABB, 2'b11);
    beat(1'b1, 1'b0, 1'b1, 16'hCCDD, 2'b11);
    chk("cs_good_err", err_o, 0);
    hdr(16'h1234, 16'd18170, 16'd12, 16'h1E1B, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABA, 2'b11);
    beat(1'b1, 1'b0, 1'b1, 16'hCCDD, 2'b11);
    chk("cs_flip_err", err_o, 1);
    hdr(16'h1234, 16'd18170, 16'd12, 16'h0000, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 16'hAABA, 2'b11);
    beat(1'b1, 1'b0, 1'b1, 16'hCCDD, 2'b11);
    chk("cs_zero_err", err_o, 0);
`endif

    beat(1'b0, 1'b0, 1'b0, 16'h0000, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
